// File: rtl/disp_row_window_buffer.sv
// Row-window producer for the disparity engine: collects raster pixels into a
// WIN+1 slot row ring and presents the oldest WIN rows as one flattened block.
module disp_row_window_buffer #(
    parameter  int WIN       = 15,
    parameter  int DATA_SIZE = 8,
    parameter  int IMG_W     = 640,
    parameter  int IMG_H     = 480,
    localparam int ROW_BITS  = $clog2(IMG_H + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_SIZE-1:0]           pix_in,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    output logic [DATA_SIZE*IMG_W*WIN-1:0] block_data,
    output logic                           block_valid,
    input  logic                           block_ack,
    output logic [ROW_BITS-1:0]            block_top,
    output logic                           last_block
);

    localparam int SLOT_BITS = $clog2(WIN + 1);
    localparam int NR_BITS   = $clog2(WIN + 2);
    localparam int COL_BITS  = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [COL_BITS-1:0]  COL_LAST  = COL_BITS'(IMG_W - 1);
    localparam logic [SLOT_BITS-1:0] SLOT_LAST = SLOT_BITS'(WIN);
    localparam logic [NR_BITS-1:0]   NR_MAX    = NR_BITS'(WIN + 1);
    localparam logic [NR_BITS-1:0]   NR_WIN    = NR_BITS'(WIN);
    localparam logic [ROW_BITS-1:0]  ROWS_ALL  = ROW_BITS'(IMG_H);
    localparam logic [ROW_BITS-1:0]  TOP_LAST  = ROW_BITS'(IMG_H - WIN);

    logic [DATA_SIZE-1:0] mem [WIN+1][IMG_W];

    logic [SLOT_BITS-1:0] wr_slot_q, wr_slot_d, top_slot_q, top_slot_d;
    logic [COL_BITS-1:0]  col_cnt_q, col_cnt_d;
    logic [NR_BITS-1:0]   n_rows_q, n_rows_d;
    logic [ROW_BITS-1:0]  rows_rcvd_q, rows_rcvd_d, block_top_q, block_top_d;
    logic                 pix_ready_q, pix_ready_d, block_valid_q, block_valid_d;

    logic xfer, row_done, ack, frame_end;

    assign xfer      = pix_valid && pix_ready_q;
    assign row_done  = xfer && (col_cnt_q == COL_LAST);
    assign ack       = block_ack && block_valid_q;
    assign last_block = block_valid_q && (block_top_q == TOP_LAST);
    assign frame_end = ack && last_block;

    always_comb begin
        wr_slot_d   = wr_slot_q;
        top_slot_d  = top_slot_q;
        col_cnt_d   = col_cnt_q;
        n_rows_d    = n_rows_q;
        rows_rcvd_d = rows_rcvd_q;
        block_top_d = block_top_q;
        if (frame_end) begin
            // The last row of the frame is already in, so no fill can race this.
            wr_slot_d   = '0;
            top_slot_d  = '0;
            col_cnt_d   = '0;
            n_rows_d    = '0;
            rows_rcvd_d = '0;
            block_top_d = '0;
        end else begin
            if (xfer)
                col_cnt_d = row_done ? '0 : col_cnt_q + COL_BITS'(1);
            if (row_done) begin
                wr_slot_d   = (wr_slot_q == SLOT_LAST) ? '0 : wr_slot_q + SLOT_BITS'(1);
                rows_rcvd_d = rows_rcvd_q + ROW_BITS'(1);
            end
            if (ack) begin
                top_slot_d  = (top_slot_q == SLOT_LAST) ? '0 : top_slot_q + SLOT_BITS'(1);
                block_top_d = block_top_q + ROW_BITS'(1);
            end
            if (row_done && !ack)
                n_rows_d = n_rows_q + NR_BITS'(1);
            else if (ack && !row_done)
                n_rows_d = n_rows_q - NR_BITS'(1);
        end
        pix_ready_d   = (n_rows_d < NR_MAX) && (rows_rcvd_d < ROWS_ALL);
        block_valid_d = (n_rows_d >= NR_WIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_slot_q     <= '0;
            top_slot_q    <= '0;
            col_cnt_q     <= '0;
            n_rows_q      <= '0;
            rows_rcvd_q   <= '0;
            block_top_q   <= '0;
            pix_ready_q   <= 1'b0;
            block_valid_q <= 1'b0;
        end else begin
            wr_slot_q     <= wr_slot_d;
            top_slot_q    <= top_slot_d;
            col_cnt_q     <= col_cnt_d;
            n_rows_q      <= n_rows_d;
            rows_rcvd_q   <= rows_rcvd_d;
            block_top_q   <= block_top_d;
            pix_ready_q   <= pix_ready_d;
            block_valid_q <= block_valid_d;
        end
    end

    // Row storage carries no reset; validity is tracked by the counters alone.
    always_ff @(posedge clk) begin
        if (xfer)
            mem[wr_slot_q][col_cnt_q] <= pix_in;
    end

    assign pix_ready   = pix_ready_q;
    assign block_valid = block_valid_q;
    assign block_top   = block_top_q;

    for (genvar r = 0; r < WIN; r++) begin : g_row
        logic [SLOT_BITS:0]   sum;
        logic [SLOT_BITS-1:0] slot;
        assign sum  = {1'b0, top_slot_q} + (SLOT_BITS+1)'(r);
        assign slot = (sum > (SLOT_BITS+1)'(WIN)) ? SLOT_BITS'(sum - (SLOT_BITS+1)'(WIN + 1))
                                                   : SLOT_BITS'(sum);
        for (genvar c = 0; c < IMG_W; c++) begin : g_col
            assign block_data[DATA_SIZE*(r*IMG_W+c) +: DATA_SIZE] = mem[slot][c];
        end
    end

endmodule

// File: tb/tb_disp_row_window_buffer.sv
// Bench for disp_row_window_buffer: directed scenarios plus random traffic,
// checked against a frame-image model (rows received vs. block top row).
module tb_disp_row_window_buffer;
  localparam int WIN = 3, IMG_W = 4, IMG_H = 5, DS = 8;
  localparam int RB = $clog2(IMG_H + 1);
  localparam int BW = DS * IMG_W * WIN;

  logic clk = 1'b0, rst = 1'b0;
  logic [DS-1:0] pix_in = '0;
  logic pix_valid = 1'b0, pix_ready, block_valid, block_ack = 1'b0, last_block;
  logic [BW-1:0] block_data;
  logic [RB-1:0] block_top;

  int chk = 0, pass = 0;

  // model: image rows as received, rows received, current column, top row
  logic [DS-1:0] img [IMG_H][IMG_W];
  int m_rcvd = 0, m_col = 0, m_top = 0;
  bit m_en = 0;

  disp_row_window_buffer #(.WIN(WIN), .DATA_SIZE(DS), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .block_data(block_data), .block_valid(block_valid), .block_ack(block_ack),
    .block_top(block_top), .last_block(last_block));

  always #5 clk = ~clk;

  function automatic bit m_valid(); return (m_rcvd - m_top) >= WIN; endfunction
  function automatic bit m_ready();
    return m_en && ((m_rcvd - m_top) < WIN + 1) && (m_rcvd < IMG_H);
  endfunction
  function automatic bit m_last(); return m_valid() && (m_top == IMG_H - WIN); endfunction
  function automatic logic [BW-1:0] exp_block();
    logic [BW-1:0] b = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++)
        if (m_top + r < IMG_H) b[DS*(r*IMG_W+c) +: DS] = img[m_top+r][c];
    return b;
  endfunction

  task automatic m_reset();
    m_rcvd = 0; m_col = 0; m_top = 0; m_en = 0;
  endtask

  // one clock of stimulus; the model advances on the same edge as the DUT
  task automatic step(input logic v, input logic [DS-1:0] p, input logic a);
    bit xf, ak, lst;
    pix_valid = v; pix_in = p; block_ack = a;
    xf = v && m_ready(); ak = a && m_valid(); lst = m_last();
    @(posedge clk);
    if (!rst) begin
      if (xf) begin
        img[m_rcvd][m_col] = p;
        m_col++;
        if (m_col == IMG_W) begin m_col = 0; m_rcvd++; end
      end
      if (ak) begin
        if (lst) begin m_rcvd = 0; m_col = 0; m_top = 0; end
        else m_top++;
      end
      m_en = 1;
    end
    #1;
    pix_valid = 1'b0; block_ack = 1'b0;
  endtask

  task automatic send_row(input int row, input int base);
    for (int c = 0; c < IMG_W; c++) step(1'b1, DS'(base + row*16 + c), 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; m_reset();
    #13;
    chk++; if (pix_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", pix_ready); else pass++;
    chk++; if (block_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", block_valid); else pass++;
    chk++; if (block_top !== '0) $display("FAIL reset_top got %0d exp 0", block_top); else pass++;
    chk++; if (last_block !== 1'b0) $display("FAIL reset_last got %b exp 0", last_block); else pass++;
    rst = 1'b0;
    step(1'b0, '0, 1'b0);
    chk++; if (pix_ready !== 1'b1) $display("FAIL release_ready got %b exp 1", pix_ready); else pass++;
  endtask

  task automatic test_fill();
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IMG_W; c++) begin
        step(1'b1, DS'(r*16 + c), 1'b0);
        chk++;
        if (block_valid !== m_valid())
          $display("FAIL fill_valid px=%0h got %b exp %b", r*16+c, block_valid, m_valid());
        else pass++;
      end
    chk++; if (block_valid !== 1'b1) $display("FAIL fill_valid_end got %b exp 1", block_valid); else pass++;
    chk++; if (block_data[31:0] !== 32'h03020100) $display("FAIL fill_row0 got %h exp 03020100", block_data[31:0]); else pass++;
    chk++; if (block_data[95:64] !== 32'h23222120) $display("FAIL fill_row2 got %h exp 23222120", block_data[95:64]); else pass++;
    chk++; if (block_data !== exp_block()) $display("FAIL fill_data got %h exp %h", block_data, exp_block()); else pass++;
    chk++; if (block_top !== RB'(0)) $display("FAIL fill_top got %0d exp 0", block_top); else pass++;
    chk++; if (last_block !== 1'b0) $display("FAIL fill_last got %b exp 0", last_block); else pass++;
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] held = block_data;
    for (int c = 0; c < IMG_W; c++) begin
      step(1'b1, DS'(3*16 + c), 1'b0);
      chk++; if (block_data !== held) $display("FAIL bp_stable c=%0d got %h exp %h", c, block_data, held); else pass++;
    end
    chk++; if (pix_ready !== 1'b0) $display("FAIL bp_ready got %b exp 0", pix_ready); else pass++;
    step(1'b1, 8'h99, 1'b0);
    chk++; if (block_data !== held) $display("FAIL bp_blocked got %h exp %h", block_data, held); else pass++;
    chk++; if (pix_ready !== 1'b0) $display("FAIL bp_ready2 got %b exp 0", pix_ready); else pass++;
  endtask

  task automatic test_slide();
    step(1'b0, '0, 1'b1);
    chk++; if (block_top !== RB'(1)) $display("FAIL slide_top got %0d exp 1", block_top); else pass++;
    chk++; if (pix_ready !== 1'b1) $display("FAIL slide_ready got %b exp 1", pix_ready); else pass++;
    chk++; if (block_data[31:0] !== 32'h13121110) $display("FAIL slide_row0 got %h exp 13121110", block_data[31:0]); else pass++;
    chk++; if (block_data !== exp_block()) $display("FAIL slide_data got %h exp %h", block_data, exp_block()); else pass++;
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < IMG_W - 1; c++) step(1'b1, DS'(4*16 + c), 1'b0);
    step(1'b1, 8'h43, 1'b1);
    chk++; if (block_valid !== 1'b1) $display("FAIL sim_valid got %b exp 1", block_valid); else pass++;
    chk++; if (block_top !== RB'(2)) $display("FAIL sim_top got %0d exp 2", block_top); else pass++;
    chk++; if (last_block !== 1'b1) $display("FAIL sim_last got %b exp 1", last_block); else pass++;
    chk++; if (block_data[95:64] !== 32'h43424140) $display("FAIL sim_row2 got %h exp 43424140", block_data[95:64]); else pass++;
    chk++; if (block_data !== exp_block()) $display("FAIL sim_data got %h exp %h", block_data, exp_block()); else pass++;
    step(1'b0, '0, 1'b1);
    chk++; if (block_valid !== 1'b0) $display("FAIL end_valid got %b exp 0", block_valid); else pass++;
    chk++; if (block_top !== RB'(0)) $display("FAIL end_top got %0d exp 0", block_top); else pass++;
    chk++; if (pix_ready !== 1'b1) $display("FAIL end_ready got %b exp 1", pix_ready); else pass++;
    chk++; if (last_block !== 1'b0) $display("FAIL end_last got %b exp 0", last_block); else pass++;
  endtask

  task automatic test_spurious_ack();
    for (int i = 0; i < 5; i++) step(1'b1, DS'((i / IMG_W)*16 + i % IMG_W), 1'b0);
    step(1'b0, '0, 1'b1);
    chk++; if (block_valid !== 1'b0) $display("FAIL spur_valid got %b exp 0", block_valid); else pass++;
    for (int i = 5; i < WIN*IMG_W; i++) step(1'b1, DS'((i / IMG_W)*16 + i % IMG_W), 1'b0);
    chk++; if (block_valid !== 1'b1) $display("FAIL spur_fill got %b exp 1", block_valid); else pass++;
    chk++; if (block_top !== RB'(0)) $display("FAIL spur_top got %0d exp 0", block_top); else pass++;
    chk++; if (block_data[31:0] !== 32'h03020100) $display("FAIL spur_row0 got %h exp 03020100", block_data[31:0]); else pass++;
  endtask

  task automatic test_async_reset();
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, DS'(8'h60 + i), 1'b0);
    #2 rst = 1'b1; m_reset();
    #1;
    chk++; if (block_valid !== 1'b0) $display("FAIL arst_valid got %b exp 0", block_valid); else pass++;
    chk++; if (pix_ready !== 1'b0) $display("FAIL arst_ready got %b exp 0", pix_ready); else pass++;
    #2 rst = 1'b0;
    step(1'b0, '0, 1'b0);
    chk++; if (pix_ready !== 1'b1) $display("FAIL arst_release got %b exp 1", pix_ready); else pass++;
    for (int r = 0; r < WIN; r++) send_row(r, 8'h80);
    chk++; if (block_valid !== 1'b1) $display("FAIL arst_fill got %b exp 1", block_valid); else pass++;
    chk++; if (block_top !== RB'(0)) $display("FAIL arst_top got %0d exp 0", block_top); else pass++;
    chk++; if (block_data[31:0] !== 32'h83828180) $display("FAIL arst_row0 got %h exp 83828180", block_data[31:0]); else pass++;
    chk++; if (block_data !== exp_block()) $display("FAIL arst_data got %h exp %h", block_data, exp_block()); else pass++;
  endtask

  task automatic test_random();
    rst = 1'b1; m_reset();
    #4 rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, DS'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
      chk++; if (block_valid !== m_valid()) $display("FAIL rnd_valid i=%0d got %b exp %b", i, block_valid, m_valid()); else pass++;
      chk++; if (pix_ready !== m_ready()) $display("FAIL rnd_ready i=%0d got %b exp %b", i, pix_ready, m_ready()); else pass++;
      chk++; if (block_top !== RB'(m_top)) $display("FAIL rnd_top i=%0d got %0d exp %0d", i, block_top, m_top); else pass++;
      chk++; if (last_block !== m_last()) $display("FAIL rnd_last i=%0d got %b exp %b", i, last_block, m_last()); else pass++;
      if (m_valid()) begin
        chk++; if (block_data !== exp_block()) $display("FAIL rnd_data i=%0d got %h exp %h", i, block_data, exp_block()); else pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_backpressure();
    test_slide();
    test_simultaneous();
    test_spurious_ack();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
